rr_arb_mux: RTL and testbench
=============================

RR_ARB_MUX -- requirements
Module: rr_arb_mux

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32: data width in bits of every channel.
REQ-002 The block SHALL have parameter N, default 8: number of input channels, legal range 2..16.
REQ-003 The block SHALL have parameter MODE, default 0: 0 = round-robin arbitration, 1 = fixed priority with lowest index winning.
REQ-004 The block SHALL have localparam SEL_W = $clog2(N).
REQ-005 The block SHALL have port clk, input, 1 bit: single clock, all state updates on the rising edge.
REQ-006 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-007 The block SHALL have port in_valid, input, N bits: bit i set means channel i offers a word.
REQ-008 The block SHALL have port in_data, input, N*WIDTH bits: channel i occupies bits [i*WIDTH +: WIDTH].
REQ-009 The block SHALL have port in_ready, output, N bits: bit i set means channel i's word is accepted this cycle.
REQ-010 The block SHALL have port out_valid, output, 1 bit: the output register holds a word.
REQ-011 The block SHALL have port out_data, output, WIDTH bits: the registered selected word.
REQ-012 The block SHALL have port out_src, output, SEL_W bits: the index of the channel that supplied out_data.
REQ-013 The block SHALL have port out_ready, input, 1 bit: the downstream consumer accepts out_data this cycle.

Function
REQ-014 A transfer SHALL occur on channel i when in_valid[i] and in_ready[i] are both high at a rising edge; an output transfer SHALL occur when out_valid and out_ready are both high.
REQ-015 The block SHALL compute can_load = !out_valid || out_ready combinationally.
REQ-016 in_ready SHALL be one-hot or zero, SHALL be nonzero only when can_load is high and at least one in_valid bit is set, and SHALL contain only the granted bit.
REQ-017 In MODE 0, the grant SHALL go to the first set in_valid bit searching upward from index ptr, wrapping from N-1 to 0.
REQ-018 In MODE 1, the grant SHALL go to the lowest set in_valid bit, and ptr SHALL be ignored.
REQ-019 On a transfer on channel g, ptr SHALL become g+1, or 0 if g = N-1; otherwise ptr SHALL hold its value.
REQ-020 On a transfer on channel g, the block SHALL load out_data <= in_data[g], out_src <= g, and out_valid <= 1 at the same edge; input-to-output latency SHALL be exactly 1 cycle.
REQ-021 On an output transfer with no input transfer, out_valid SHALL become 0, and out_data and out_src SHALL hold their values.
REQ-022 On simultaneous output and input transfers, the new word SHALL replace the old one with out_valid staying 1, sustaining one word per cycle.
REQ-023 While out_valid=1 and out_ready=0, out_data and out_src SHALL remain stable, and in_ready SHALL be all zero.
REQ-024 When there is no in_valid, there SHALL be no grant, ptr SHALL be unchanged, and the output register SHALL follow REQ-021 or REQ-023.
REQ-025 Arbitration SHALL never drop, duplicate or reorder words from a single channel.
REQ-026 In MODE 0, any continuously asserted channel SHALL be granted within N grants.
REQ-027 There SHALL be no combinational path from out_ready to out_data or out_valid.

Reset
REQ-028 When reset is high at a rising edge, the block SHALL set out_valid=0, out_data=0, out_src=0 and ptr=0.
REQ-029 Reset SHALL take priority over all transfers in that cycle, and a held word SHALL be discarded.
REQ-030 While reset is high, in_ready SHALL be all zero.

Verification
REQ-031 Reset then N=8, MODE 0, in_valid=8'hFF, out_ready=1 for 10 cycles -> out_src sequence SHALL be 0,1,2,3,4,5,6,7,0,1 and out_valid SHALL stay 1 after the first cycle.
REQ-032 MODE 0 with ptr at 6 and in_valid=8'b0000_0101 -> grant SHALL go to channel 0 (wrap), then ptr=1, and the next grant SHALL go to channel 2.
REQ-033 MODE 1 with in_valid=8'b1010_0000, then 8'b1010_0001 -> grants SHALL be 5, then 0, and channel 7 SHALL never be granted while a lower channel requests.
REQ-034 Word on channel 3 = 32'hDEADBEEF with out_ready=0 for 4 cycles -> out_data=32'hDEADBEEF and out_src=3 SHALL be held, in_ready=0 for those cycles, and the word SHALL be released once when out_ready=1.
REQ-035 Reset asserted while out_valid=1 and out_ready=0 -> the next cycle SHALL show out_valid=0, out_data=0 and ptr=0, and the held word SHALL never appear.
REQ-036 A random valid/ready scoreboard over 10k cycles -> every accepted input word SHALL appear exactly once, in per-channel order, with the correct out_src.

Source files
------------

// File: rtl/rr_arb_mux.sv
// rr_arb_mux: N-channel valid/ready arbiter feeding a single registered output.
//
// Each input channel offers a WIDTH-bit word. One channel per cycle is granted
// and its word is captured into an output register along with its index.
// Arbitration is round-robin (MODE 0) or fixed priority, lowest index first (MODE 1).
// The output register behaves as a one-deep pipeline stage: a new word may be
// loaded whenever the register is empty or is being drained in the same cycle.
//
// Parameters
//   WIDTH  data width of every channel
//   N      number of input channels (2..16)
//   MODE   0 = round-robin, 1 = fixed priority (lowest index wins)
//
// Ports
//   clk        clock, rising edge
//   reset      synchronous active-high reset
//   in_valid   [N]        channel i offers a word
//   in_data    [N*WIDTH]  channel i word at [i*WIDTH +: WIDTH]
//   in_ready   [N]        one-hot (or zero) grant; word accepted this cycle
//   out_valid             output register holds a word
//   out_data   [WIDTH]    registered selected word
//   out_src    [SEL_W]    index of the channel that supplied out_data
//   out_ready             downstream accepts out_data this cycle

module rr_arb_mux #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned N     = 8,
  parameter int unsigned MODE  = 0,
  localparam int unsigned SEL_W = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N-1:0]         in_valid,
  input  logic [N*WIDTH-1:0]   in_data,
  output logic [N-1:0]         in_ready,
  output logic                 out_valid,
  output logic [WIDTH-1:0]     out_data,
  output logic [SEL_W-1:0]     out_src,
  input  logic                 out_ready
);

  // Round-robin pointer: the channel searched first on the next grant.
  logic [SEL_W-1:0] ptr_q, ptr_d;

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [SEL_W-1:0] out_src_q, out_src_d;

  logic             can_load;
  logic             grant_found;
  logic [SEL_W-1:0] grant_idx;
  logic             in_fire;

  // The register may take a new word when empty or when its word leaves now.
  // out_ready only feeds in_ready and the register's next state, never the
  // registered outputs directly.
  assign can_load = !out_valid_q || out_ready;

  // Grant search. In round-robin the scan starts at ptr_q and wraps at N-1;
  // in fixed priority it starts at 0 and ptr_q is ignored.
  always_comb begin : arbiter
    int unsigned cand;
    cand        = 0;
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (MODE == 1) begin
        cand = k;
      end else begin
        cand = int'(ptr_q) + k;
        if (cand >= N) begin
          cand = cand - N;
        end
      end
      if (!grant_found && in_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = SEL_W'(cand);
      end
    end
  end

  // Reset suppresses every handshake so nothing is consumed during reset.
  assign in_fire = !reset && can_load && grant_found;

  always_comb begin : ready_gen
    in_ready = '0;
    if (in_fire) begin
      in_ready[grant_idx] = 1'b1;
    end
  end

  always_comb begin : next_state
    ptr_d       = ptr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    if (in_fire) begin
      // Load (possibly replacing a word leaving this same cycle).
      ptr_d       = (grant_idx == SEL_W'(N - 1)) ? '0 : grant_idx + 1'b1;
      out_valid_d = 1'b1;
      out_data_d  = in_data[int'(grant_idx) * WIDTH +: WIDTH];
      out_src_d   = grant_idx;
    end else if (out_ready) begin
      // Drain only: data and source keep their last values.
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin : state_reg
    if (reset) begin
      ptr_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= '0;
    end else begin
      ptr_q       <= ptr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_src   = out_src_q;

endmodule

// File: tb/tb_rr_arb_mux.sv
// Bench for rr_arb_mux: one round-robin and one fixed-priority instance share
// the same stimulus. Each grant predicted by a reference model is pushed into
// a per-instance queue; a monitor pops and compares on output transfers.

module tb_rr_arb_mux;

  localparam int unsigned W = 32;
  localparam int unsigned NC = 8;

  typedef struct {
    int          src;
    logic [31:0] data;
  } exp_t;

  logic              clk;
  logic              reset;
  logic [NC-1:0]     in_valid;
  logic [NC*W-1:0]   in_data;
  logic              out_ready;

  logic [NC-1:0]     irdy  [2];
  logic              ov    [2];
  logic [W-1:0]      odata [2];
  logic [2:0]        osrc  [2];

  logic [31:0]       data_w [NC];

  exp_t sb [2][$];
  int   mptr [2];
  bit   mv   [2];

  int checks = 0;
  int errors = 0;

  rr_arb_mux #(.WIDTH(W), .N(NC), .MODE(0)) dut_rr (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (irdy[0]),
    .out_valid (ov[0]),
    .out_data  (odata[0]),
    .out_src   (osrc[0]),
    .out_ready (out_ready)
  );

  rr_arb_mux #(.WIDTH(W), .N(NC), .MODE(1)) dut_fp (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (irdy[1]),
    .out_valid (ov[1]),
    .out_data  (odata[1]),
    .out_src   (osrc[1]),
    .out_ready (out_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference arbitration: round-robin scans upward from ptr with wrap,
  // fixed priority picks the lowest requesting channel.
  function automatic int model_grant(input logic [7:0] v, input int ptr, input int mode);
    if (mode == 1) begin
      for (int i = 0; i < 8; i++) if (v[i]) return i;
      return -1;
    end
    for (int k = 0; k < 8; k++) if (v[(ptr + k) % 8]) return (ptr + k) % 8;
    return -1;
  endfunction

  // Called at posedge+1; drives one cycle, predicts, returns at next posedge+1.
  task automatic step(input logic [7:0] v, input logic rdy, input logic rst);
    int g;
    logic [7:0] exp_rdy;
    in_valid  = v;
    out_ready = rdy;
    reset     = rst;
    for (int i = 0; i < NC; i++) in_data[i*W +: W] = data_w[i];
    #1;
    for (int d = 0; d < 2; d++) begin
      chk(d == 0 ? "rr out_valid" : "fp out_valid", {31'b0, ov[d]}, {31'b0, mv[d]});
      if (rst || !(!mv[d] || rdy)) g = -1;
      else g = model_grant(v, mptr[d], d);
      exp_rdy = (g < 0) ? 8'h00 : (8'h01 << g);
      chk(d == 0 ? "rr in_ready" : "fp in_ready", {24'b0, irdy[d]}, {24'b0, exp_rdy});
      if (rst) begin
        mv[d]   = 1'b0;
        mptr[d] = 0;
      end else if (g >= 0) begin
        sb[d].push_back('{src: g, data: data_w[g]});
        mptr[d] = (g + 1) % 8;
        mv[d]   = 1'b1;
      end else if (rdy) begin
        mv[d] = 1'b0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: mid-cycle, the front of each queue must be the word on display.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if (reset === 1'b1) begin
          sb[d].delete();
        end else if (ov[d] === 1'b1) begin
          if (sb[d].size() == 0) begin
            checks++;
            errors++;
            $display("FAIL dut%0d unexpected word: src %0d data %0h expected none",
                     d, osrc[d], odata[d]);
          end else begin
            e = sb[d][0];
            chk(d == 0 ? "rr sb out_src" : "fp sb out_src", {29'b0, osrc[d]}, e.src);
            chk(d == 0 ? "rr sb out_data" : "fp sb out_data", odata[d], e.data);
            if (out_ready === 1'b1) void'(sb[d].pop_front());
          end
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < NC; i++) data_w[i] = 32'hA5A5_0000 + i;
    for (int d = 0; d < 2; d++) begin
      mptr[d] = 0;
      mv[d]   = 1'b0;
    end
    reset = 1'b1; in_valid = '0; out_ready = 1'b0; in_data = '0;
    @(posedge clk);
    #1;
    step(8'h00, 1'b0, 1'b1);
    step(8'h00, 1'b0, 1'b1);
    for (int d = 0; d < 2; d++) begin
      chk("reset out_valid", {31'b0, ov[d]}, 32'd0);
      chk("reset out_data", odata[d], 32'd0);
      chk("reset out_src", {29'b0, osrc[d]}, 32'd0);
    end

    // All channels requesting: round-robin walks 0..7 and wraps.
    for (int k = 0; k < 10; k++) begin
      step(8'hFF, 1'b1, 1'b0);
      chk("rr sweep out_src", {29'b0, osrc[0]}, k % 8);
      chk("rr sweep out_valid", {31'b0, ov[0]}, 32'd1);
      chk("fp sweep out_src", {29'b0, osrc[1]}, 32'd0);
    end

    // Pointer wrap: grant 5 puts ptr at 6, then {2,0} requested gives 0 then 2.
    step(8'h00, 1'b1, 1'b1);
    step(8'h20, 1'b1, 1'b0);
    step(8'h05, 1'b1, 1'b0);
    chk("rr wrap grant", {29'b0, osrc[0]}, 32'd0);
    step(8'h05, 1'b1, 1'b0);
    chk("rr after wrap grant", {29'b0, osrc[0]}, 32'd2);

    // Fixed priority: 5 wins alone, then 0 beats 5 and 7.
    step(8'hA0, 1'b1, 1'b0);
    chk("fp grant 5", {29'b0, osrc[1]}, 32'd5);
    step(8'hA1, 1'b1, 1'b0);
    chk("fp grant 0", {29'b0, osrc[1]}, 32'd0);
    step(8'hA1, 1'b1, 1'b0);
    chk("fp grant 0 again", {29'b0, osrc[1]}, 32'd0);
    step(8'h00, 1'b1, 1'b0);

    // Back-pressure: word from channel 3 held for 4 cycles.
    data_w[3] = 32'hDEADBEEF;
    step(8'h08, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      step(8'hFF, 1'b0, 1'b0);
      for (int d = 0; d < 2; d++) begin
        chk("stall out_valid", {31'b0, ov[d]}, 32'd1);
        chk("stall out_data", odata[d], 32'hDEADBEEF);
        chk("stall out_src", {29'b0, osrc[d]}, 32'd3);
        chk("stall in_ready", {24'b0, irdy[d]}, 32'd0);
      end
    end
    step(8'h00, 1'b1, 1'b0);
    chk("release rr out_valid", {31'b0, ov[0]}, 32'd0);
    chk("release fp out_valid", {31'b0, ov[1]}, 32'd0);

    // Reset while a word is held: the word is discarded, pointer returns to 0.
    step(8'h08, 1'b0, 1'b0);
    step(8'hFF, 1'b0, 1'b1);
    for (int d = 0; d < 2; d++) begin
      chk("held reset out_valid", {31'b0, ov[d]}, 32'd0);
      chk("held reset out_data", odata[d], 32'd0);
    end
    step(8'hFF, 1'b1, 1'b0);
    chk("rr ptr after reset", {29'b0, osrc[0]}, 32'd0);
    chk("rr data after reset", odata[0], 32'hA5A5_0000);

    // Random traffic against the scoreboard.
    for (int c = 0; c < 10000; c++) begin
      for (int i = 0; i < NC; i++) data_w[i] = $urandom;
      step(8'($urandom), ($urandom_range(3, 0) != 0), 1'b0);
    end
    step(8'h00, 1'b1, 1'b0);
    step(8'h00, 1'b1, 1'b0);
    step(8'h00, 1'b1, 1'b0);
    @(negedge clk);
    chk("rr scoreboard drained", sb[0].size(), 32'd0);
    chk("fp scoreboard drained", sb[1].size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
